// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master and its downstream transfer decoder.
package apb_master_pkg;

    // Master sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // Rd_Wr_Id encoding consumed by the downstream decoder.
    localparam int unsigned RW_ID_W = 2;
    localparam logic [RW_ID_W-1:0] RW_READ  = 2'b00;
    localparam logic [RW_ID_W-1:0] RW_WRITE = 2'b01;
    localparam logic [RW_ID_W-1:0] RW_IDLE  = 2'b10;

    // Classifies the bus cycle from the APB control pins; a transfer is
    // reported only while it is in its ACCESS phase.
    function automatic logic [RW_ID_W-1:0] rd_wr_id(
        input logic psel,
        input logic penable,
        input logic pwrite
    );
        logic [RW_ID_W-1:0] id;
        id = RW_IDLE;
        if (psel && penable) begin
            id = pwrite ? RW_WRITE : RW_READ;
        end
        return id;
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: turns a valid/ready request into one APB transfer and returns
// a single-cycle response, aborting transfers whose slave never responds.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    // Requests are only taken while the bus is idle.
    assign req_ready = (state == ST_IDLE);

    // Next-state and next-output computation.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;

        case (state)
            ST_IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (req_valid) begin
                    state_nxt  = ST_SETUP;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = req_write;
                    paddr_nxt  = req_addr;
                    if (req_write) begin
                        pwdata_nxt = req_wdata;
                    end
                    cnt_nxt    = '0;
                end
            end

            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
            end

            ST_ACCESS: begin
                if (pready) begin
                    // Slave completion takes priority over a coincident timeout.
                    state_nxt     = ST_IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = ST_IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with hand-computed expectations.
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #1;
        n_checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== '0 ||
            pwdata !== '0 || rsp_rdata !== '0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: psel=%0b penable=%0b pwrite=%0b rsp_valid=%0b rsp_err=%0b paddr=%h pwdata=%h rdata=%h ready=%0b, required all 0 and ready=1",
                     psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, req_ready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hA5A5A5A5;
        prdata = 32'hFFFF_FFFF; pready = 1'b1; pslverr = 1'b0;
        tick();                                   // edge N: accept
        req_valid = 1'b0; req_addr = 32'hDEAD_0000; req_wdata = 32'h0;
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 32'h10 ||
            pwdata !== 32'hA5A5A5A5 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_setup: psel=%0b penable=%0b pwrite=%0b paddr=%h pwdata=%h ready=%0b, required 1 0 1 00000010 a5a5a5a5 0",
                     psel, penable, pwrite, paddr, pwdata, req_ready);
        end
        tick();                                   // edge N+1: ACCESS
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0 ||
            rd_wr_id(psel, penable, pwrite) !== RW_WRITE || paddr !== 32'h10) begin
            n_fail++;
            $display("FAIL write_access: psel=%0b penable=%0b rsp_valid=%0b id=%b paddr=%h, required 1 1 0 01 00000010",
                     psel, penable, rsp_valid, rd_wr_id(psel, penable, pwrite), paddr);
        end
        tick();                                   // edge N+2: complete
        pready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0 ||
            penable !== 1'b0 || req_ready !== 1'b1 || paddr !== 32'h10 ||
            rd_wr_id(psel, penable, pwrite) !== RW_IDLE) begin
            n_fail++;
            $display("FAIL write_rsp: rsp_valid=%0b err=%0b rdata=%h psel=%0b penable=%0b ready=%0b paddr=%h id=%b, required 1 0 0 0 0 1 00000010 10",
                     rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready, paddr, rd_wr_id(psel, penable, pwrite));
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp_pulse: rsp_valid=%0b psel=%0b, required 0 0", rsp_valid, psel);
        end
    endtask

    task automatic test_read_wait();
        int access_cycles;
        access_cycles = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        prdata = 32'h0BAD_0BAD; pready = 1'b0; pslverr = 1'b0;
        tick();                                   // accept
        req_valid = 1'b0; req_addr = 32'h0;
        tick();                                   // first ACCESS cycle
        for (int i = 0; i < 3; i++) begin
            if (psel === 1'b1 && penable === 1'b1 && paddr === 32'h20 && rsp_valid === 1'b0)
                access_cycles++;
            tick();
        end
        if (psel === 1'b1 && penable === 1'b1 && paddr === 32'h20) access_cycles++;
        pready = 1'b1; prdata = 32'h12345678;
        tick();
        pready = 1'b0; prdata = 32'h0;
        n_checks++;
        if (access_cycles !== 4) begin
            n_fail++;
            $display("FAIL read_wait_access_len: stable ACCESS cycles=%0d, required 4", access_cycles);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait_rsp: rsp_valid=%0b err=%0b rdata=%h psel=%0b, required 1 0 12345678 0",
                     rsp_valid, rsp_err, rsp_rdata, psel);
        end
        tick();
    endtask

    task automatic test_timeout();
        int access_cycles;
        access_cycles = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30;
        prdata = 32'hFFFF_FFFF; pready = 1'b0; pslverr = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 40 && psel === 1'b1; i++) begin
            access_cycles++;
            tick();
        end
        n_checks++;
        if (access_cycles !== 16) begin
            n_fail++;
            $display("FAIL timeout_len: ACCESS cycles=%0d, required 16", access_cycles);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_rsp: rsp_valid=%0b err=%0b rdata=%h penable=%0b, required 1 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata, penable);
        end
        prdata = 32'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h1111_2222;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
        tick();                                   // edge N: first accept
        req_write = 1'b0; req_addr = 32'h50;      // req_valid stays high
        tick();                                   // N+1: ACCESS
        tick();                                   // N+2: complete
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL slverr_rsp: rsp_valid=%0b err=%0b rdata=%h ready=%0b, required 1 1 0 1",
                     rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        tick();                                   // N+3: second accept
        req_valid = 1'b0; pslverr = 1'b0;
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'h50 ||
            rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: psel=%0b penable=%0b pwrite=%0b paddr=%h rsp_valid=%0b ready=%0b, required 1 0 0 00000050 0 0",
                     psel, penable, pwrite, paddr, rsp_valid, req_ready);
        end
        tick();
        tick();
        pready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL b2b_read_rsp: rsp_valid=%0b err=%0b rdata=%h, required 1 0 cafef00d",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h60;
        pready = 1'b0; prdata = 32'h7777_7777;
        tick();
        req_valid = 1'b0;
        tick();
        tick();                                   // waiting in ACCESS
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: psel=%0b penable=%0b paddr=%h rsp_valid=%0b ready=%0b, required 0 0 0 0 1",
                     psel, penable, paddr, rsp_valid, req_ready);
        end
        pready = 1'b1;
        repeat (2) begin
            tick();
            if (rsp_valid !== 1'b0) spurious++;
        end
        rst_n = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h64; req_wdata = 32'h5;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: req_ready=%0b, required 1", req_ready);
        end
        tick();                                   // first edge after release
        req_valid = 1'b0;
        if (rsp_valid !== 1'b0) spurious++;
        n_checks++;
        if (psel !== 1'b1 || paddr !== 32'h64 || pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_accept: psel=%0b paddr=%h pwrite=%0b, required 1 00000064 1",
                     psel, paddr, pwrite);
        end
        tick();
        tick();                                   // completes (pready still 1)
        pready = 1'b0;
        tick();
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: spurious rsp_valid cycles=%0d, required 0", spurious);
        end
    endtask

    task automatic test_timeout_boundary();
        int access_cycles;
        access_cycles = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            if (psel === 1'b1 && penable === 1'b1) access_cycles++;
            tick();
        end
        if (psel === 1'b1 && penable === 1'b1) access_cycles++;
        n_checks++;
        if (access_cycles !== 16) begin
            n_fail++;
            $display("FAIL boundary_still_access: ACCESS cycles before 16th edge=%0d, required 16", access_cycles);
        end
        pready = 1'b1; prdata = 32'h0BADCAFE;
        tick();
        pready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BADCAFE) begin
            n_fail++;
            $display("FAIL boundary_rsp: rsp_valid=%0b err=%0b rdata=%h, required 1 0 0badcafe",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_timeout_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, max consecutive ACCESS cycles with pready low before abort; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  transaction request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-008 req_write  input  1  1=write, 0=read.
REQ-009 req_addr  input  ADDR_W  transaction address.
REQ-010 req_wdata  input  DATA_W  write data; ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  pslverr sampled at completion, or 1 on timeout.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-016 prdata  input  DATA_W; pready  input  1; pslverr  input  1  APB slave response.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; all APB outputs registered (no combinational path from req_* to APB pins).
REQ-018 req_ready = 1 only in IDLE (combinational from state only).
REQ-019 IDLE, handshake -> SETUP next cycle; paddr/pwdata/pwrite captured from request in the same edge.
REQ-020 SETUP: psel=1, penable=0; always -> ACCESS after exactly one cycle.
REQ-021 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite held stable for whole ACCESS.
REQ-022 ACCESS with pready=1 -> IDLE; rsp_valid=1 next cycle with rsp_err=pslverr, rsp_rdata=prdata (read) or 0 (write), all sampled at that edge.
REQ-023 ACCESS with pready=0: wait counter increments; when counter reaches TIMEOUT-1 and pready still 0 -> IDLE, rsp_valid=1 next cycle with rsp_err=1, rsp_rdata=0.
REQ-024 pready=1 in the same cycle timeout would fire: normal completion wins.
REQ-025 Wait counter cleared on entry to SETUP; width $clog2(TIMEOUT).
REQ-026 Minimum spacing: accept at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid N+3 (zero wait states); next accept earliest at edge N+3.
REQ-027 In IDLE psel=penable=0; paddr/pwdata/pwrite keep last values.
REQ-028 pready/pslverr/prdata ignored outside ACCESS.
REQ-029 rsp_valid is never asserted for more than one consecutive cycle.

Reset
REQ-030 rst_n low -> immediately: state IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, wait counter 0.
REQ-031 Reset mid-transaction aborts it silently; no rsp_valid is produced for it.
REQ-032 First acceptance possible at first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package holds the state enum (IDLE/SETUP/ACCESS) and the Rd_Wr_Id encoding constants (READ=2'b00, WRITE=2'b01, IDLE=2'b10) used by the downstream decoder.
REQ-034 Single flat module; no sub-modules; one sequential block for state/registers, one combinational block for next-state.

Verification
REQ-035 Write addr 0x10, wdata 0xA5A5A5A5, pready=1 at once -> psel rises N+1, penable N+2, rsp_valid N+3 with rsp_err=0, rsp_rdata=0; downstream decoder shows WRITE for one cycle.
REQ-036 Read addr 0x20, pready low 3 cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles, paddr stable, rsp_rdata=0x12345678.
REQ-037 Read with pready held low, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-038 Write with pslverr=1, pready=1 -> rsp_err=1; next back-to-back request with req_valid held high accepted exactly at rsp_valid edge.
REQ-039 rst_n pulled low during ACCESS of a read -> psel/penable 0 immediately, no rsp_valid, req_ready=1 after release.
REQ-040 pready asserted on the 16th waited cycle (TIMEOUT=16) -> normal completion, rsp_err=pslverr=0.
